// File: rtl/cache_mem_arbiter.sv
// cpu_types_pkg: shared RAM status encoding used by the cache memory path.
package cpu_types_pkg;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

// cache_mem_arbiter: grants the single-ported RAM to the icache or dcache
// (data side has priority, pre-empting instruction fetches only at word
// boundaries) and returns the wait/load handshake to the granted requester.
// Ports:
//   CLK, nRST                 clock, async active-low reset
//   iREN, iaddr               instruction fetch request / address
//   iwait, iload              fetch handshake (low on completion) / data
//   dREN, dWEN, daddr, dstore data read/write request, address, write data
//   dwait, dload              data handshake (low on completion) / data
//   ramREN, ramWEN, ramaddr, ramstore, ramload, ramstate   RAM port
//   memerr                    sticky: RAM reported ERROR during a grant
module cache_mem_arbiter
    import cpu_types_pkg::*;
(
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    iREN,
    input  logic [WORD_W-1:0]       iaddr,
    output logic                    iwait,
    output logic [WORD_W-1:0]       iload,
    input  logic                    dREN,
    input  logic                    dWEN,
    input  logic [WORD_W-1:0]       daddr,
    input  logic [WORD_W-1:0]       dstore,
    output logic                    dwait,
    output logic [WORD_W-1:0]       dload,
    output logic                    ramREN,
    output logic                    ramWEN,
    output logic [WORD_W-1:0]       ramaddr,
    output logic [WORD_W-1:0]       ramstore,
    input  logic [WORD_W-1:0]       ramload,
    input  ramstate_t               ramstate,
    output logic                    memerr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DSERV = 2'd1,
        ISERV = 2'd2
    } state_t;

    state_t state, next_state;
    logic   dreq;

    assign dreq = dREN | dWEN;

    // Grant register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state arbitration; data side wins ties and pre-empts at word ends
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (dreq) begin
                    next_state = DSERV;
                end else if (iREN) begin
                    next_state = ISERV;
                end
            end
            DSERV: begin
                if (!dreq) begin
                    next_state = iREN ? ISERV : IDLE;
                end
            end
            ISERV: begin
                if ((ramstate == ACCESS) && dreq) begin
                    next_state = DSERV;
                end else if (!iREN) begin
                    next_state = dreq ? DSERV : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // RAM drive and handshake, combinational from grant and requester inputs
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (state)
            DSERV: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = (ramstate != ACCESS);
            end
            ISERV: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iwait   = (ramstate != ACCESS);
            end
            default: ;
        endcase
    end

    // Load data is broadcast; only meaningful in the completion cycle
    assign iload = ramload;
    assign dload = ramload;

    // Sticky error flag, set by an ERROR status while any grant is held
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            memerr <= 1'b0;
        end else if ((state != IDLE) && (ramstate == ERROR)) begin
            memerr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;
    import cpu_types_pkg::*;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    ramstate_t   ramstate;
    logic        memerr;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic        is_d;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];

    cache_mem_arbiter dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .memerr   (memerr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic drive_slot();
        @(posedge CLK);
        #2;
    endtask

    task automatic sample_slot();
        @(negedge CLK);
    endtask

    // Scoreboard: every completion pops the oldest expected transaction.
    always @(negedge CLK) begin
        if (nRST === 1'b1 && (iwait === 1'b0 || dwait === 1'b0)) begin
            exp_t e;
            logic ok;
            logic [31:0] got_data;
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_unexpected: completion iwait=%b dwait=%b ramaddr=%h with nothing expected",
                         iwait, dwait, ramaddr);
            end else begin
                e  = sb.pop_front();
                ok = 1'b1;
                if (iwait === 1'b0 && dwait === 1'b0) ok = 1'b0;
                if (e.is_d && dwait !== 1'b0) ok = 1'b0;
                if (!e.is_d && iwait !== 1'b0) ok = 1'b0;
                if (ramaddr !== e.addr) ok = 1'b0;
                if (e.wen) begin
                    got_data = ramstore;
                    if (ramWEN !== 1'b1 || ramREN !== 1'b0) ok = 1'b0;
                end else begin
                    got_data = e.is_d ? dload : iload;
                    if (ramREN !== 1'b1 || ramWEN !== 1'b0) ok = 1'b0;
                end
                if (got_data !== e.data) ok = 1'b0;
                if (!ok) begin
                    tests_failed++;
                    $display("FAIL sb_completion: got iwait=%b dwait=%b addr=%h data=%h ren=%b wen=%b, required side=%s addr=%h data=%h wen=%b",
                             iwait, dwait, ramaddr, got_data, ramREN, ramWEN,
                             e.is_d ? "D" : "I", e.addr, e.data, e.wen);
                end
            end
        end
    end

    task automatic idle_inputs();
        iREN     = 1'b0;
        iaddr    = '0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        ramload  = '0;
        ramstate = FREE;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        idle_inputs();
        repeat (2) sample_slot();
        tests_run++;
        if (ramREN !== 1'b0 || ramWEN !== 1'b0 || iwait !== 1'b1 || dwait !== 1'b1 ||
            memerr !== 1'b0 || ramaddr !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: ren=%b wen=%b iwait=%b dwait=%b memerr=%b addr=%h, required 0 0 1 1 0 00000000",
                     ramREN, ramWEN, iwait, dwait, memerr, ramaddr);
        end
        drive_slot();
        nRST = 1'b1;
        sample_slot();
    endtask

    task automatic test_ifetch();
        int ilows = 0;
        drive_slot();
        iREN = 1'b1; iaddr = 32'h40; ramstate = FREE;
        sample_slot();
        tests_run++;
        if (ramREN !== 1'b0 || iwait !== 1'b1) begin
            tests_failed++;
            $display("FAIL ifetch_latency: ren=%b iwait=%b in grant cycle, required 0 1", ramREN, iwait);
        end
        for (int c = 0; c < 2; c++) begin
            drive_slot();
            ramstate = BUSY;
            sample_slot();
            if (iwait === 1'b0) ilows++;
            tests_run++;
            if (ramREN !== 1'b1 || ramaddr !== 32'h40 || iwait !== 1'b1) begin
                tests_failed++;
                $display("FAIL ifetch_busy: ren=%b addr=%h iwait=%b, required 1 00000040 1", ramREN, ramaddr, iwait);
            end
        end
        drive_slot();
        ramstate = ACCESS; ramload = 32'hDEADBEEF;
        sb.push_back('{is_d: 1'b0, wen: 1'b0, addr: 32'h40, data: 32'hDEADBEEF});
        sample_slot();
        if (iwait === 1'b0) ilows++;
        drive_slot();
        iREN = 1'b0; ramstate = FREE; ramload = '0;
        sample_slot();
        if (iwait === 1'b0) ilows++;
        drive_slot();
        sample_slot();
        if (iwait === 1'b0) ilows++;
        tests_run++;
        if (ilows != 1) begin
            tests_failed++;
            $display("FAIL ifetch_pulse: iwait low for %0d cycles, required 1", ilows);
        end
    endtask

    task automatic test_simultaneous();
        drive_slot();
        iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h100;
        sample_slot();
        drive_slot();
        ramstate = ACCESS; ramload = 32'hAAAA0001;
        sb.push_back('{is_d: 1'b1, wen: 1'b0, addr: 32'h100, data: 32'hAAAA0001});
        sample_slot();
        tests_run++;
        if (ramaddr !== 32'h100 || iwait !== 1'b1) begin
            tests_failed++;
            $display("FAIL simul_dfirst: addr=%h iwait=%b, required 00000100 1", ramaddr, iwait);
        end
        drive_slot();
        dREN = 1'b0; ramstate = FREE;
        sample_slot();
        drive_slot();
        ramstate = ACCESS; ramload = 32'hBBBB0002;
        sb.push_back('{is_d: 1'b0, wen: 1'b0, addr: 32'h80, data: 32'hBBBB0002});
        sample_slot();
        tests_run++;
        if (ramaddr !== 32'h80 || ramREN !== 1'b1) begin
            tests_failed++;
            $display("FAIL simul_handoff: addr=%h ren=%b, required 00000080 1", ramaddr, ramREN);
        end
        drive_slot();
        idle_inputs();
        sample_slot();
    endtask

    task automatic test_back_to_back();
        int dlows = 0;
        int iacc  = 0;
        drive_slot();
        dWEN = 1'b1; daddr = 32'h200; dstore = 32'h11; iREN = 1'b1; iaddr = 32'h500;
        sample_slot();
        drive_slot();
        ramstate = BUSY;
        sample_slot();
        if (ramREN === 1'b1) iacc++;
        drive_slot();
        ramstate = ACCESS;
        sb.push_back('{is_d: 1'b1, wen: 1'b1, addr: 32'h200, data: 32'h11});
        sample_slot();
        if (dwait === 1'b0) dlows++;
        if (ramREN === 1'b1) iacc++;
        drive_slot();
        daddr = 32'h204; dstore = 32'h22;
        sb.push_back('{is_d: 1'b1, wen: 1'b1, addr: 32'h204, data: 32'h22});
        sample_slot();
        if (dwait === 1'b0) dlows++;
        if (ramREN === 1'b1) iacc++;
        drive_slot();
        dWEN = 1'b0; ramstate = FREE;
        sample_slot();
        if (ramREN === 1'b1) iacc++;
        tests_run++;
        if (iacc != 0 || dlows != 2) begin
            tests_failed++;
            $display("FAIL b2b_words: I accesses=%0d dwait pulses=%0d, required 0 2", iacc, dlows);
        end
        drive_slot();
        ramstate = ACCESS; ramload = 32'h55;
        sb.push_back('{is_d: 1'b0, wen: 1'b0, addr: 32'h500, data: 32'h55});
        sample_slot();
        tests_run++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h500) begin
            tests_failed++;
            $display("FAIL b2b_igrant: ren=%b addr=%h, required 1 00000500", ramREN, ramaddr);
        end
        drive_slot();
        idle_inputs();
        sample_slot();
    endtask

    task automatic test_preempt();
        drive_slot();
        iREN = 1'b1; iaddr = 32'h600; ramstate = BUSY;
        sample_slot();
        drive_slot();
        sample_slot();
        for (int c = 0; c < 2; c++) begin
            drive_slot();
            dWEN = 1'b1; daddr = 32'h300; dstore = 32'h33;
            sample_slot();
            tests_run++;
            if (ramaddr !== 32'h600 || ramREN !== 1'b1 || ramWEN !== 1'b0 || dwait !== 1'b1) begin
                tests_failed++;
                $display("FAIL preempt_wait: addr=%h ren=%b wen=%b dwait=%b, required 00000600 1 0 1",
                         ramaddr, ramREN, ramWEN, dwait);
            end
        end
        drive_slot();
        ramstate = ACCESS; ramload = 32'h66;
        sb.push_back('{is_d: 1'b0, wen: 1'b0, addr: 32'h600, data: 32'h66});
        sample_slot();
        drive_slot();
        dREN = 1'b1;
        sb.push_back('{is_d: 1'b1, wen: 1'b1, addr: 32'h300, data: 32'h33});
        sample_slot();
        tests_run++;
        if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h300) begin
            tests_failed++;
            $display("FAIL preempt_both_en: wen=%b ren=%b addr=%h, required 1 0 00000300", ramWEN, ramREN, ramaddr);
        end
        drive_slot();
        idle_inputs();
        sample_slot();
        drive_slot();
        sample_slot();
        tests_run++;
        if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== 32'h0) begin
            tests_failed++;
            $display("FAIL preempt_idle: ren=%b wen=%b addr=%h, required 0 0 00000000", ramREN, ramWEN, ramaddr);
        end
    endtask

    task automatic test_error_reset();
        drive_slot();
        dREN = 1'b1; daddr = 32'h700;
        sample_slot();
        drive_slot();
        ramstate = ERROR;
        sample_slot();
        tests_run++;
        if (memerr !== 1'b0 || dwait !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_first: memerr=%b dwait=%b, required 0 1", memerr, dwait);
        end
        drive_slot();
        ramstate = BUSY;
        sample_slot();
        tests_run++;
        if (memerr !== 1'b1 || dwait !== 1'b1 || ramREN !== 1'b1 || ramaddr !== 32'h700) begin
            tests_failed++;
            $display("FAIL err_set: memerr=%b dwait=%b ren=%b addr=%h, required 1 1 1 00000700",
                     memerr, dwait, ramREN, ramaddr);
        end
        drive_slot();
        ramstate = FREE; dREN = 1'b0; dWEN = 1'b1;
        sample_slot();
        tests_run++;
        if (memerr !== 1'b1 || dwait !== 1'b1 || ramWEN !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_sticky: memerr=%b dwait=%b wen=%b, required 1 1 1", memerr, dwait, ramWEN);
        end
        #1;
        nRST = 1'b0;
        #1;
        tests_run++;
        if (memerr !== 1'b0 || ramWEN !== 1'b0 || ramREN !== 1'b0 || dwait !== 1'b1 || iwait !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_async_reset: memerr=%b wen=%b ren=%b dwait=%b iwait=%b, required 0 0 0 1 1",
                     memerr, ramWEN, ramREN, dwait, iwait);
        end
        idle_inputs();
        drive_slot();
        nRST = 1'b1;
        sample_slot();
    endtask

    initial begin
        test_reset();
        test_ifetch();
        test_simultaneous();
        test_back_to_back();
        test_preempt();
        test_error_reset();
        repeat (2) sample_slot();
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_drain: %0d expected completions never seen, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Memory-side responder for the cache request interface: services instruction-cache fetches and data-cache fills and write-backs against a single-ported RAM. It sits between the icache/dcache request ports and the RAM model, one level below the caches.
- Arbitrates between the two requesters, with data-side priority.
- Drives the single RAM request.
- Returns the wait/load handshake to the requester that holds the grant.

## Interface
Parameters:
- none (word width fixed at 32; RAM state encoding from `cpu_types_pkg::ramstate_t`: FREE=0, BUSY=1, ACCESS=2, ERROR=3)

Ports:
- CLK  in  1  system clock; all state updates on the rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction fetch request
- iaddr  in  32  instruction fetch address
- iwait  out  1  low for exactly the cycle the fetch completes
- iload  out  32  fetch data
- dREN  in  1  data read (fill) request
- dWEN  in  1  data write (write-back) request
- daddr  in  32  data address
- dstore  in  32  write data
- dwait  out  1  low for exactly the cycle the data access completes
- dload  out  32  read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  RAM status
- memerr  out  1  sticky flag: RAM reported ERROR during a granted access

## Operation
- FSM states: IDLE, DSERV, ISERV. Reset state is IDLE; memerr resets to 0.
- **IDLE**
  - dREN|dWEN → DSERV.
  - Otherwise iREN → ISERV.
  - Otherwise stay in IDLE.
- **DSERV**
  - Stay while dREN|dWEN is asserted. This covers multi-word block transfers: the dcache keeps its request high while stepping daddr.
  - When dREN|dWEN drops: iREN → ISERV, otherwise → IDLE.
- **ISERV**
  - On a completion cycle (ramstate==ACCESS) with dREN|dWEN pending → DSERV. The data side pre-empts only at word boundaries.
  - Otherwise stay while iREN is asserted.
  - When iREN drops: dREN|dWEN → DSERV, otherwise → IDLE.
- **RAM drive (combinational from state)**
  - DSERV:
    - ramWEN=dWEN.
    - ramREN=dREN&~dWEN; dWEN wins if both are asserted.
    - ramaddr=daddr, ramstore=dstore.
  - ISERV: ramREN=iREN, ramWEN=0, ramaddr=iaddr, ramstore=0.
  - IDLE: ramREN=ramWEN=0, ramaddr=0, ramstore=0.
- **Handshake**
  - dwait = ~(state==DSERV & ramstate==ACCESS).
  - iwait = ~(state==ISERV & ramstate==ACCESS).
  - A non-granted requester always sees wait=1.
- **Load data:** dload=ramload and iload=ramload, unconditionally. The data is only meaningful in the requester's completion cycle.
- **Errors:** ramstate==ERROR while in DSERV or ISERV sets memerr=1 until reset. The access is not completed (wait stays 1); the FSM stays put and keeps driving the request.
- A request whose address changes while waiting is forwarded as-is. The arbiter does not latch addresses.

## Timing
- Arbitration latency: 1 cycle from request assertion in IDLE to the RAM enable. The grant is registered; enables are combinational from state and requester inputs.
- Back-to-back words within one grant have no bubble. The next word's enable appears in the cycle after completion.
- Grant handoff (D→I or I→D) costs 1 cycle: the new enable appears in the cycle after the state change.
- A simultaneous iREN and dREN/dWEN rise in IDLE goes to DSERV.
- Reset asserted mid-access: the FSM returns to IDLE immediately (asynchronously). All RAM enables drop, both waits read 1, and memerr clears.
- ramstate FREE/BUSY during a grant: wait=1 and the enables are held.

## Test plan
- **Reset:** nRST=0 → state IDLE, ramREN=ramWEN=0, iwait=dwait=1, memerr=0.
- **Instruction fetch:** iREN=1, iaddr=0x40, RAM returns ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF.
  - ramREN=1 and ramaddr=0x40 from cycle 1.
  - iwait=0 exactly one cycle, with iload=0xDEADBEEF.
- **Simultaneous requests:** iREN=1, iaddr=0x80 and dREN=1, daddr=0x100 rise in the same cycle.
  - Data is served first (ramaddr=0x100).
  - After dREN drops, ramaddr=0x80 one cycle later.
- **Block write-back:** dWEN held across two words, daddr 0x200 then 0x204, dstore 0x11 then 0x22, with iREN=1 pending.
  - Both RAM writes occur with no I access in between.
  - dwait pulses low twice.
  - iREN is granted only after dWEN drops.
- **Pre-emption and both-enables:**
  - While in ISERV, assert dWEN=1, daddr=0x300 → the transition to DSERV happens only at the I completion cycle.
  - dREN=dWEN=1 → ramWEN=1, ramREN=0.
- **Error and reset:** ramstate=ERROR during DSERV.
  - memerr=1 and stays 1 after ERROR clears; dwait=1 throughout.
  - Assert nRST mid-access → memerr=0, ramWEN=0 asynchronously.
